// File: rtl/calc_accum.sv
// calc_accum: sequential accumulator stage around a combinational W-bit calculator.
// One command at a time enters over a valid/ready handshake. It executes with the
// accumulator as operand A and the command data as operand B. The result is held
// on a second valid/ready handshake until downstream accepts it.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. A sender keeps valid and its payload stable until
// that edge. Ready never depends on valid. in_ready is a pure decode of IDLE.
// out_valid is a register that stays high, with its payload frozen, until the
// transfer.

// Combinational calculator: two's complement with wrap and a signed-overflow flag.
module comb_calc #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic [W-1:0] r_o,
    output logic         ovf_o
);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] sum_w;
    logic [W-1:0] a_minus_b_w;
    logic [W-1:0] b_minus_a_w;

    assign sum_w       = a_i + b_i;
    assign a_minus_b_w = a_i - b_i;
    assign b_minus_a_w = b_i - a_i;

    // Select the result and overflow for the opcode. Abs of MIN wraps to MIN and flags overflow.
    always_comb begin
        r_o   = '0;
        ovf_o = 1'b0;
        case (op_i)
            3'b000, 3'b100: begin
                r_o   = sum_w;
                ovf_o = (a_i[W-1] == b_i[W-1]) && (sum_w[W-1] != a_i[W-1]);
            end
            3'b001: begin
                r_o   = a_minus_b_w;
                ovf_o = (a_i[W-1] != b_i[W-1]) && (a_minus_b_w[W-1] != a_i[W-1]);
            end
            3'b101: begin
                r_o   = b_minus_a_w;
                ovf_o = (b_i[W-1] != a_i[W-1]) && (b_minus_a_w[W-1] != b_i[W-1]);
            end
            3'b010, 3'b011: begin
                r_o   = b_i[W-1] ? (~b_i + 1'b1) : b_i;
                ovf_o = (b_i == MIN_VAL);
            end
            3'b110, 3'b111: begin
                r_o   = a_i[W-1] ? (~a_i + 1'b1) : a_i;
                ovf_o = (a_i == MIN_VAL);
            end
            default: begin
                r_o   = '0;
                ovf_o = 1'b0;
            end
        endcase
    end
endmodule

module calc_accum #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_clr,
    input  logic [2:0]   in_op,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_acc,
    output logic         out_ovf,
    output logic         sticky_ovf,
    output logic [7:0]   out_cnt,
    output logic [1:0]   dbg_state,
    output logic [W-1:0] dbg_acc
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t       state_q;
    logic [W-1:0] acc_q;
    logic [2:0]   op_q;
    logic         clr_q;
    logic [W-1:0] opnd_q;
    logic [W-1:0] out_acc_q;
    logic         out_ovf_q;
    logic         sticky_ovf_q;
    logic [7:0]   out_cnt_q;
    logic         out_valid_q;

    logic [W-1:0] calc_r_d;
    logic         calc_ovf_d;

    // The calculator always sees the latched command; its result is used only in EXEC.
    comb_calc #(.W(W)) u_calc (
        .a_i   (acc_q),
        .b_i   (opnd_q),
        .op_i  (op_q),
        .r_o   (calc_r_d),
        .ovf_o (calc_ovf_d)
    );

    // Command FSM. It latches in IDLE, writes back in EXEC, and holds the result until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            op_q         <= '0;
            clr_q        <= 1'b0;
            opnd_q       <= '0;
            out_acc_q    <= '0;
            out_ovf_q    <= 1'b0;
            sticky_ovf_q <= 1'b0;
            out_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        clr_q   <= in_clr;
                        opnd_q  <= in_data;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (clr_q) begin
                        // A load restarts the overflow history and the operation count.
                        acc_q        <= opnd_q;
                        out_acc_q    <= opnd_q;
                        out_ovf_q    <= 1'b0;
                        sticky_ovf_q <= 1'b0;
                        out_cnt_q    <= '0;
                    end else begin
                        // Wrapped result is kept even on overflow; the counter wraps naturally.
                        acc_q        <= calc_r_d;
                        out_acc_q    <= calc_r_d;
                        out_ovf_q    <= calc_ovf_d;
                        sticky_ovf_q <= sticky_ovf_q | calc_ovf_d;
                        out_cnt_q    <= out_cnt_q + 8'd1;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_acc    = out_acc_q;
    assign out_ovf    = out_ovf_q;
    assign sticky_ovf = sticky_ovf_q;
    assign out_cnt    = out_cnt_q;
    assign dbg_state  = state_q;
    assign dbg_acc    = acc_q;
endmodule

// File: doc/calc_accum.md
# calc_accum

Sequential accumulator stage wrapped around the combinational calculator (`CombCalc`, W-bit, 3-bit opcode). It accepts one command at a time over a valid/ready handshake and runs it through the calculator with the accumulator as operand A and the command data as operand B. The result is written back to the accumulator and presented downstream over a second valid/ready handshake. It also tracks overflow (per-result and sticky) and counts operations since the last load.

## Interface
- `W`, default 16: datapath width; passed to the calculator instance.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  command valid.
- `in_ready`  out  1  command accept; high only in IDLE.
- `in_clr`  in  1  load command: ACC <= `in_data`; `in_op` ignored.
- `in_op`  in  3  calculator opcode.
- `in_data`  in  W  signed operand B, or load value.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accept.
- `out_acc`  out  W  signed accumulator value after the command.
- `out_ovf`  out  1  overflow of this result.
- `sticky_ovf`  out  1  OR of all `out_ovf` since the last load or reset.
- `out_cnt`  out  8  arithmetic commands completed since the last load or reset.

## Operation
- Opcodes, with A = ACC and B = operand register:
  - 000: A+B
  - 001: A−B
  - 01x: |B|
  - 100: B+A
  - 101: B−A
  - 11x: |A|
- Arithmetic is two's complement with wrap; ACC takes the calculator result R unchanged, even when `ovf` = 1. There is no saturation.
- |−2^(W−1)| yields −2^(W−1) with `ovf` = 1.
- Registers:
  - ACC
  - op_r and clr_r
  - opnd_r
  - `out_acc`, `out_ovf`, `sticky_ovf`, `out_cnt`
  - state: IDLE, EXEC, HOLD
- IDLE: `in_ready` = 1. On `in_valid` & `in_ready`, latch `in_op`, `in_clr`, `in_data`, then go to EXEC.
- EXEC: the calculator is driven from ACC, op_r and opnd_r. On the next edge:
  - Arithmetic command: ACC <= R; `out_acc` <= R; `out_ovf` <= ovf; `sticky_ovf` |= ovf; `out_cnt` += 1 (wraps 255 to 0).
  - Load command: ACC <= opnd_r; `out_acc` <= opnd_r; `out_ovf` <= 0; `sticky_ovf` <= 0; `out_cnt` <= 0.
  - Then set `out_valid` <= 1 and go to HOLD.
- HOLD: `out_valid` = 1 and all outputs are stable. On `out_valid` & `out_ready`, clear `out_valid` and go to IDLE.
- `in_valid` outside IDLE is not accepted; the sender must hold the command.
- `out_ready` while `out_valid` = 0 has no effect.

## Timing
- Reset (edge with `rst_n` = 0):
  - state = IDLE
  - ACC, `out_acc`, `out_ovf`, `sticky_ovf`, `out_cnt`, `out_valid` = 0
  - op_r, clr_r, opnd_r = 0
- `in_ready` is 1 after the reset edge, and applies from any state.
- `in_ready` is a decode of state == IDLE and never depends on `in_valid`.
- Latency: command accepted on edge k → `out_valid` = 1 after edge k+1.
- With `out_ready` held at 1: handshake on edge k+2 → IDLE, next accept on edge k+3. Sustained throughput is 1 command per 3 cycles.
- Backpressure: HOLD persists indefinitely while `out_ready` = 0; ACC and outputs do not change.
- Reset mid-operation (EXEC or HOLD): the pending command is discarded; all outputs take reset values on that edge and no partial ACC write occurs.
- A command may be presented in the same cycle as the HOLD handshake, but it is accepted only once in IDLE, i.e. one cycle later.
- `out_ovf` reflects only the most recent result; `sticky_ovf` persists until a load or reset.

## Test plan
- Reset, then load 100 → after 2 cycles: `out_valid` = 1, `out_acc` = 100, `out_ovf` = 0, `sticky_ovf` = 0, `out_cnt` = 0.
- With ACC = 100:
  - op 001, data 30 → `out_acc` = 70, `out_cnt` = 1.
  - Then op 101, data 30 → `out_acc` = 0xFFD8 (−40), `out_cnt` = 2, `out_ovf` = 0.
- Overflow:
  - Load 0x7FFF, op 000, data 1 → `out_acc` = 0x8000, `out_ovf` = 1, `sticky_ovf` = 1.
  - Then op 000, data 0 → `out_acc` = 0x8000, `out_ovf` = 0, `sticky_ovf` = 1.
  - Then load 5 → `sticky_ovf` = 0.
- Absolute value:
  - Load −5, op 110 → `out_acc` = 5.
  - Op 010, data −7 → `out_acc` = 7.
  - Load 0x8000, op 111 → `out_acc` = 0x8000, `out_ovf` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles after a result while pulsing `in_valid` → `out_valid` stays 1, `in_ready` = 0, `out_acc` and ACC unchanged, no command accepted. Release → IDLE on the next edge.
- Reset in EXEC: assert `rst_n` = 0 for one edge while in EXEC → `out_valid` = 0, ACC = 0, `out_cnt` = 0, `in_ready` = 1; no result emitted.
